intr_ctrl: RTL

- Programmable interrupt controller between the bridge's per-device interrupt lines and the CPU's HW_INT input.
- Latches edge or level requests from up to N_SRC devices (timer, UART, ...), applies the enable mask, and picks one winner by fixed priority (lower index wins).
- Presents the winner to the CPU as a stable one-hot HW_INT and tracks it through an ACK/EOI handshake.
- Registers are written and read through the bridge as an ordinary device slot.

---
 rtl/intr_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - fixed-priority interrupt controller with edge/level latching and ACK/EOI handshake
module intr_ctrl #(
    parameter int N_SRC = 6,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [31:0]      data_in,
    output logic [31:0]      data_out,
    input  logic [N_SRC-1:0] int_req_x,
    output logic             irq,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] hw_int
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_SERVICE = 2'b10
    } state_t;

    localparam logic [N_SRC-1:0] SRC_ONE = {{(N_SRC-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             gen_q, gen_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] req_q, req_d;
    logic [N_SRC-1:0] latch_q, latch_d;

    logic [N_SRC-1:0] pend, eff, id_onehot, ack_clr, w1c, edge_set;
    logic [ID_W-1:0]  win;
    logic             id_active;
    logic             wr_ctrl, wr_mask, wr_mode, wr_cmd, ack, eoi;
    logic             unused_data;

    assign unused_data = ^data_in[29:N_SRC];

    assign wr_ctrl = we && (addr == 2'd0);
    assign wr_mask = we && (addr == 2'd1);
    assign wr_mode = we && (addr == 2'd2);
    assign wr_cmd  = we && (addr == 2'd3);
    assign ack     = wr_cmd && data_in[30];
    assign eoi     = wr_cmd && data_in[31];

    // Edge latch runs for every source; only edge-mode sources expose it through pend.
    always_comb begin
        pend      = (mode_q & latch_q) | (~mode_q & req_q);
        eff       = gen_q ? (pend & mask_q) : '0;
        id_onehot = SRC_ONE << id_q;
        id_active = |(eff & id_onehot);
        win       = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eff[i]) begin
                win = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ack_clr = '0;
        case (state_q)
            ST_IDLE: begin
                if (|eff) begin
                    state_d = ST_REQ;
                    id_d    = win;
                end
            end
            ST_REQ: begin
                if (!id_active) begin
                    state_d = ST_IDLE;
                    id_d    = '0;
                end else if (ack) begin
                    state_d = ST_SERVICE;
                    ack_clr = id_onehot & mode_q;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                    id_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                id_d    = '0;
            end
        endcase
    end

    // A new edge beats a same-cycle clear; a 0->1 MODE write always empties the latch.
    always_comb begin
        gen_d    = wr_ctrl ? data_in[0] : gen_q;
        mask_d   = wr_mask ? data_in[N_SRC-1:0] : mask_q;
        mode_d   = wr_mode ? data_in[N_SRC-1:0] : mode_q;
        req_d    = int_req_x;
        edge_set = int_req_x & ~req_q;
        w1c      = wr_cmd ? data_in[N_SRC-1:0] : '0;
        latch_d  = (latch_q & ~(w1c | ack_clr)) | edge_set;
        if (wr_mode) begin
            latch_d = latch_d & ~(data_in[N_SRC-1:0] & ~mode_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            gen_q   <= 1'b0;
            mask_q  <= '0;
            mode_q  <= '0;
            req_q   <= '0;
            latch_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            gen_q   <= gen_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            req_q   <= req_d;
            latch_q <= latch_d;
        end
    end

    assign irq    = (state_q == ST_REQ);
    assign irq_id = id_q;
    assign hw_int = irq ? id_onehot : '0;

    always_comb begin
        data_out = '0;
        case (addr)
            2'd0: data_out[0] = gen_q;
            2'd1: data_out = 32'(mask_q);
            2'd2: data_out = 32'(mode_q);
            default: begin
                data_out[31:30]      = state_q;
                data_out[16 +: ID_W] = id_q;
                data_out[N_SRC-1:0]  = pend;
            end
        endcase
    end

endmodule
